mips_controller: RTL

Multicycle control unit for the 8-bit MIPS datapath. Sequences one instruction at a time through byte-wide fetch, decode, execute, memory and writeback states, and drives every mux select and write enable of the datapath (PC, instruction register, register file, ALU, memory port). It decodes lb, sb, R-type (add, sub, and, or, slt), beq, j and addi, and supports a global stall from the memory side.

---
 rtl/mips_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mips_controller.sv
// Multicycle Moore control unit for the 8-bit MIPS datapath (lb, sb, R-type, beq, j, addi).
// Optional build macro MIPS_CTRL_ILLEGAL_TRAP_EN: undefined opcodes trap into HALT and raise illegal.
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       stall,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14,
        HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_r;
    state_t     next_state_s;
    logic       memread_s;
    logic       memwrite_s;
    logic [3:0] irwrite_s;
    logic       pcen_s;
    logic       regwrite_s;
    logic       kill_s;

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        logic [2:0] ctl;
        case (f)
            6'b100000: ctl = 3'b010;
            6'b100010: ctl = 3'b110;
            6'b100100: ctl = 3'b000;
            6'b100101: ctl = 3'b001;
            6'b101010: ctl = 3'b111;
            default:   ctl = 3'b010;
        endcase
        return ctl;
    endfunction

    // State register: reset wins over stall, stall freezes the sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH1;
        end else if (!stall) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state sequencing
    always_comb begin
        next_state_s = FETCH1;
        case (state_r)
            FETCH1:  next_state_s = FETCH2;
            FETCH2:  next_state_s = FETCH3;
            FETCH3:  next_state_s = FETCH4;
            FETCH4:  next_state_s = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = RTYPEEX;
                    OP_BEQ:       next_state_s = BEQEX;
                    OP_J:         next_state_s = JEX;
                    OP_ADDI:      next_state_s = ADDIEX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:      next_state_s = HALT;
`else
                    default:      next_state_s = FETCH1;
`endif
                endcase
            end
            MEMADR: begin
                if (op == OP_LB) begin
                    next_state_s = LBRD;
                end else if (op == OP_SB) begin
                    next_state_s = SBWR;
                end else begin
                    next_state_s = FETCH1;
                end
            end
            LBRD:    next_state_s = LBWR;
            LBWR:    next_state_s = FETCH1;
            SBWR:    next_state_s = FETCH1;
            RTYPEEX: next_state_s = RTYPEWR;
            RTYPEWR: next_state_s = FETCH1;
            BEQEX:   next_state_s = FETCH1;
            JEX:     next_state_s = FETCH1;
            ADDIEX:  next_state_s = ADDIWR;
            ADDIWR:  next_state_s = FETCH1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            HALT:    next_state_s = HALT;
`else
            HALT:    next_state_s = FETCH1;
`endif
            default: next_state_s = FETCH1;
        endcase
    end

    // Moore output decode before stall/reset gating of the write enables
    always_comb begin
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        iord       = 1'b0;
        irwrite_s  = 4'b0000;
        pcen_s     = 1'b0;
        pcsource   = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b010;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        case (state_r)
            FETCH1:  begin memread_s = 1'b1; irwrite_s = 4'b0001; alusrcb = 2'b01; pcen_s = 1'b1; end
            FETCH2:  begin memread_s = 1'b1; irwrite_s = 4'b0010; alusrcb = 2'b01; pcen_s = 1'b1; end
            FETCH3:  begin memread_s = 1'b1; irwrite_s = 4'b0100; alusrcb = 2'b01; pcen_s = 1'b1; end
            FETCH4:  begin memread_s = 1'b1; irwrite_s = 4'b1000; alusrcb = 2'b01; pcen_s = 1'b1; end
            DECODE:  alusrcb = 2'b11;
            MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            LBRD:    begin memread_s = 1'b1; iord = 1'b1; end
            LBWR:    begin regwrite_s = 1'b1; memtoreg = 1'b1; end
            SBWR:    begin memwrite_s = 1'b1; iord = 1'b1; end
            RTYPEEX: begin alusrca = 1'b1; alucontrol = rtype_alu(funct); end
            RTYPEWR: begin regwrite_s = 1'b1; regdst = 1'b1; end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                pcen_s     = zero;
            end
            JEX:     begin pcsource = 2'b10; pcen_s = 1'b1; end
            ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            ADDIWR:  regwrite_s = 1'b1;
            HALT:    pcen_s = 1'b0;
            default: pcen_s = 1'b0;
        endcase
    end

    // Stall keeps memread presented so the memory access stays valid; reset kills it
    assign kill_s   = reset | stall;
    assign memread  = memread_s & ~reset;
    assign memwrite = memwrite_s & ~kill_s;
    assign pcen     = pcen_s & ~kill_s;
    assign regwrite = regwrite_s & ~kill_s;
    assign irwrite  = irwrite_s & {4{~kill_s}};
    assign state    = state_r;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_r == HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule
